// File: rtl/fixed_lut_index_pipe.sv
// Two-stage, multi-lane LUT address generator: leading-one detect, normalise to
// Q1.(WIDTH-1), then split the fraction into LUT index and interpolation residual.
module fixed_lut_index_pipe #(
  parameter int WIDTH       = 16,
  parameter int LUT_POW     = 5,
  parameter int RES_WIDTH   = 4,
  parameter int PARALLELISM = 4,
  localparam int MSB_WIDTH  = $clog2(WIDTH),
  localparam int RW         = (RES_WIDTH > 0) ? RES_WIDTH : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PARALLELISM*WIDTH-1:0]   data_in,
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  output logic [PARALLELISM*LUT_POW-1:0] index_out,
  output logic [PARALLELISM*RW-1:0]      residual_out,
  output logic [PARALLELISM*MSB_WIDTH-1:0] msb_out,
  output logic [PARALLELISM-1:0]         zero_out,
  output logic                           data_out_valid,
  input  logic                           data_out_ready
);

  // Fraction padded on the right so index/residual slices never run off the end.
  localparam int EXT_W = (WIDTH - 1) + LUT_POW + RW;

  // Handshake: a beat moves into a stage on a clk edge when the upstream valid
  // and the stage's ready are both high; a stage is ready when empty or when
  // its own content leaves in the same cycle, so a full pipe streams 1 beat/cycle.
  logic s1_valid, s2_valid;
  logic s1_ready, s2_ready;

  logic [PARALLELISM*WIDTH-1:0]     s1_val;
  logic [PARALLELISM*MSB_WIDTH-1:0] s1_msb;
  logic [PARALLELISM-1:0]           s1_zero;

  logic [PARALLELISM*MSB_WIDTH-1:0] lod_msb;
  logic [PARALLELISM-1:0]           lod_zero;

  logic [PARALLELISM*LUT_POW-1:0]   nxt_index;
  logic [PARALLELISM*RW-1:0]        nxt_res;

  assign s2_ready       = !s2_valid || data_out_ready;
  assign s1_ready       = !s1_valid || s2_ready;
  assign data_in_ready  = s1_ready;
  assign data_out_valid = s2_valid;

  // Leading-one detection: the highest set bit wins because it is written last.
  always_comb begin
    logic [WIDTH-1:0] lane;
    lane     = '0;
    lod_msb  = '0;
    lod_zero = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      lane        = data_in[i*WIDTH +: WIDTH];
      lod_zero[i] = (lane == '0);
      for (int b = 0; b < WIDTH; b++) begin
        if (lane[b]) lod_msb[i*MSB_WIDTH +: MSB_WIDTH] = MSB_WIDTH'(b);
      end
    end
  end

  // Normalise so the leading one sits at bit WIDTH-1, drop it, slice the fraction.
  always_comb begin
    logic [MSB_WIDTH-1:0] shamt;
    logic [WIDTH-1:0]     norm;
    logic [EXT_W-1:0]     ext;
    shamt     = '0;
    norm      = '0;
    ext       = '0;
    nxt_index = '0;
    nxt_res   = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      shamt = MSB_WIDTH'(WIDTH - 1) - s1_msb[i*MSB_WIDTH +: MSB_WIDTH];
      norm  = s1_val[i*WIDTH +: WIDTH] << shamt;
      ext   = {norm[WIDTH-2:0], {(LUT_POW + RW){1'b0}}};
      nxt_index[i*LUT_POW +: LUT_POW] = ext[EXT_W-1 -: LUT_POW];
      if (RES_WIDTH > 0) nxt_res[i*RW +: RW] = ext[EXT_W-1-LUT_POW -: RW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_val       <= '0;
      s1_msb       <= '0;
      s1_zero      <= '0;
      s2_valid     <= 1'b0;
      index_out    <= '0;
      residual_out <= '0;
      msb_out      <= '0;
      zero_out     <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= data_in_valid;
        if (data_in_valid) begin
          s1_val  <= data_in;
          s1_msb  <= lod_msb;
          s1_zero <= lod_zero;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          index_out    <= nxt_index;
          residual_out <= nxt_res;
          msb_out      <= s1_msb;
          zero_out     <= s1_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_lut_index_pipe.sv
// Bench for fixed_lut_index_pipe: directed corner values, stall/drain, throughput,
// mid-flight reset and randomized streaming against an arithmetic reference model.
module tb_fixed_lut_index_pipe;

  localparam int W  = 16;
  localparam int L  = 5;
  localparam int R  = 4;
  localparam int RW = 4;
  localparam int P  = 4;
  localparam int MW = 4;
  localparam int OUT_W = P * (L + RW + MW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [P*W-1:0]   data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [P*L-1:0]   index_out;
  logic [P*RW-1:0]  residual_out;
  logic [P*MW-1:0]  msb_out;
  logic [P-1:0]     zero_out;
  logic             data_out_valid;
  logic             data_out_ready;

  logic rand_mode, rnd_ready, force_ready;
  assign data_out_ready = rand_mode ? rnd_ready : force_ready;

  // Second instance: narrow input with a LUT wider than the fraction.
  logic [5:0] b_data;
  logic       b_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_index;
  logic [3:0] b_res;
  logic [2:0] b_msb;
  logic       b_zero;

  int n_checks = 0;
  int n_err    = 0;
  logic [OUT_W-1:0] exp_q[$];
  longint t_first, t_last;

  fixed_lut_index_pipe #(.WIDTH(W), .LUT_POW(L), .RES_WIDTH(R), .PARALLELISM(P)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .index_out(index_out), .residual_out(residual_out),
    .msb_out(msb_out), .zero_out(zero_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  fixed_lut_index_pipe #(.WIDTH(6), .LUT_POW(8), .RES_WIDTH(4), .PARALLELISM(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data), .data_in_valid(b_valid),
    .data_in_ready(b_in_ready), .index_out(b_index), .residual_out(b_res),
    .msb_out(b_msb), .zero_out(b_zero), .data_out_valid(b_out_valid),
    .data_out_ready(b_out_ready)
  );

  // Clock / reset-independent infrastructure
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: leading-one position by repeated halving, then the fraction
  // below it scaled to LUT_POW+RES_WIDTH bits by plain integer arithmetic.
  function automatic logic [OUT_W-1:0] model(input logic [P*W-1:0] d);
    logic [P*L-1:0]  ix;
    logic [P*RW-1:0] rs;
    logic [P*MW-1:0] ms;
    logic [P-1:0]    zs;
    longint v, f, ir;
    int m;
    ix = '0; rs = '0; ms = '0; zs = '0;
    for (int i = 0; i < P; i++) begin
      v = longint'(d[i*W +: W]);
      if (v == 0) begin
        zs[i] = 1'b1;
      end else begin
        m = 0;
        while ((v >> (m + 1)) != 0) m++;
        f  = (v << (W - 1 - m)) - (longint'(1) << (W - 1));
        ir = (f << (L + R)) >> (W - 1);
        ix[i*L +: L]   = L'(ir >> R);
        rs[i*RW +: RW] = RW'(ir & ((1 << R) - 1));
        ms[i*MW +: MW] = MW'(m);
      end
    end
    return {ix, rs, ms, zs};
  endfunction

  function automatic logic [P*W-1:0] rand_beat();
    logic [P*W-1:0] d;
    for (int i = 0; i < P; i++) d[i*W +: W] = W'($urandom) >> $urandom_range(0, W);
    return d;
  endfunction

  // Scoreboard: every beat leaving the DUT must be the oldest one expected.
  always @(negedge clk) begin
    if (rst && data_out_valid && data_out_ready) begin
      check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0)
        check("beat_data", 128'({index_out, residual_out, msb_out, zero_out}), 128'(exp_q.pop_front()));
    end
  end

  // Driver: present a beat, wait (bounded) for acceptance, log its expectation.
  task automatic send(input logic [P*W-1:0] d);
    bit r;
    int t;
    r = 1'b0;
    t = 0;
    data_in       = d;
    data_in_valid = 1'b1;
    while (!r && t < 200) begin
      @(negedge clk);
      r = data_in_ready;
      @(posedge clk);
      t++;
    end
    check("send_accepted", 128'(r), 128'(1));
    if (r) begin
      exp_q.push_back(model(d));
      t_last = $time;
    end
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // Idle pipe: check 2-cycle latency and the lane-0 fields against literal values.
  task automatic directed(input logic [15:0] v, input int emsb, input int eidx,
                          input int eres, input int ez);
    logic [P*W-1:0] d;
    d             = {W'($urandom), W'($urandom), W'($urandom), v};
    data_in       = d;
    data_in_valid = 1'b1;
    @(negedge clk);
    check("dir_in_ready", 128'(data_in_ready), 128'(1));
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    exp_q.push_back(model(d));
    @(negedge clk);
    check("latency_1cyc_valid", 128'(data_out_valid), 128'(0));
    @(negedge clk);
    check("latency_2cyc_valid", 128'(data_out_valid), 128'(1));
    check("dir_msb",   128'(msb_out[MW-1:0]),     128'(emsb));
    check("dir_index", 128'(index_out[L-1:0]),    128'(eidx));
    check("dir_res",   128'(residual_out[RW-1:0]), 128'(eres));
    check("dir_zero",  128'(zero_out[0]),         128'(ez));
    @(posedge clk);
    #1;
  endtask

  task automatic directed_b(input logic [5:0] v, input int emsb, input int eidx,
                            input int eres, input int ez);
    b_data  = v;
    b_valid = 1'b1;
    @(negedge clk);
    check("b_in_ready", 128'(b_in_ready), 128'(1));
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b_valid", 128'(b_out_valid), 128'(1));
    check("b_msb",   128'(b_msb),   128'(emsb));
    check("b_index", 128'(b_index), 128'(eidx));
    check("b_res",   128'(b_res),   128'(eres));
    check("b_zero",  128'(b_zero),  128'(ez));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [P*W-1:0] b3;

    // Reset
    rst = 1'b0; data_in = '0; data_in_valid = 1'b0;
    rand_mode = 1'b0; force_ready = 1'b1;
    b_data = '0; b_valid = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({index_out, residual_out, msb_out, zero_out}), 128'(0));
    check("reset_out_valid", 128'(data_out_valid), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 128'(data_in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Directed corner values
    directed(16'h00B4, 7, 13, 0, 0);
    directed(16'h0001, 0, 0, 0, 0);
    directed(16'hFFFF, 15, 31, 15, 0);
    directed(16'h8000, 15, 0, 0, 0);
    directed(16'h0000, 0, 0, 0, 1);
    send({16'hFFFF, 16'h00B4, 16'h0001, 16'h0000});
    wait_drain();

    // Stall: two beats fill the pipe, the third must wait with outputs frozen
    @(posedge clk);
    #1;
    force_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    b3 = rand_beat();
    data_in = b3;
    data_in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", 128'(data_out_valid), 128'(1));
      check("stall_in_ready", 128'(data_in_ready), 128'(0));
      check("stall_hold", 128'({index_out, residual_out, msb_out, zero_out}), 128'(exp_q[0]));
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    force_ready = 1'b1;
    send(b3);
    send(rand_beat());
    wait_drain();

    // Throughput: 100 back-to-back beats, one accepted per cycle
    for (int k = 0; k < 100; k++) begin
      send(rand_beat());
      if (k == 0) t_first = t_last;
    end
    check("throughput_cycles", 128'((t_last - t_first) / 10), 128'(99));
    wait_drain();

    // Reset with two beats in flight
    @(posedge clk);
    #1;
    force_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_flush_out_valid", 128'(data_out_valid), 128'(0));
    check("rst_flush_in_ready", 128'(data_in_ready), 128'(1));
    check("rst_flush_outputs", 128'({index_out, residual_out, msb_out, zero_out}), 128'(0));
    @(posedge clk);
    #1;
    force_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_stale", 128'(data_out_valid), 128'(0));
    end
    @(posedge clk);
    #1;

    // Randomized streaming with random backpressure and idle gaps
    rand_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_beat());
    end
    wait_drain();
    rand_mode = 1'b0;

    // Narrow instance: fraction zero-padded on the right to fill the index
    directed_b(6'h2D, 5, 8'h68, 0, 0);
    directed_b(6'h3F, 5, 8'hF8, 0, 0);
    directed_b(6'h05, 2, 8'h40, 0, 0);
    directed_b(6'h01, 0, 0, 0, 0);
    directed_b(6'h00, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
